// File: rtl/change_dispenser_if.sv
// Change dispenser bus: transaction request, restock load, hopper handshake
// and status/inventory read-back grouped behind master/slave modports.
interface change_dispenser_if #(
  parameter int unsigned INV_W = 4
) ();
  logic             start;
  logic [4:0]       change_amt;
  logic             restock;
  logic [INV_W-1:0] restock_5;
  logic [INV_W-1:0] restock_2;
  logic [INV_W-1:0] restock_1;
  logic             hopper_ack;
  logic             dispense_5;
  logic             dispense_2;
  logic             dispense_1;
  logic             busy;
  logic             done;
  logic             short_err;
  logic             fault;
  logic [4:0]       owed;
  logic [INV_W-1:0] inv_5;
  logic [INV_W-1:0] inv_2;
  logic [INV_W-1:0] inv_1;

  modport master (
    output start, change_amt, restock, restock_5, restock_2, restock_1, hopper_ack,
    input  dispense_5, dispense_2, dispense_1, busy, done, short_err, fault,
           owed, inv_5, inv_2, inv_1
  );

  modport slave (
    input  start, change_amt, restock, restock_5, restock_2, restock_1, hopper_ack,
    output dispense_5, dispense_2, dispense_1, busy, done, short_err, fault,
           owed, inv_5, inv_2, inv_1
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin change dispenser (5/2/1) with per-coin inventory, hopper
// acknowledge handshake and acknowledge timeout.
module change_dispenser #(
  parameter int unsigned INV_W       = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);

  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, FINISH} state_t;
  typedef enum logic [1:0] {COIN_NONE, COIN_5, COIN_2, COIN_1} coin_t;

  state_t           state, next_state;
  coin_t            coin, sel_coin;
  logic [TW-1:0]    tcnt;
  logic [4:0]       owed;
  logic [4:0]       coin_val;
  logic [INV_W-1:0] inv_5, inv_2, inv_1;
  logic             short_q, fault_q;
  logic             ack_hit, tmo_hit;

  // Greedy coin choice, handshake decode and next-state logic
  always_comb begin
    sel_coin   = COIN_NONE;
    coin_val   = 5'd0;
    ack_hit    = 1'b0;
    tmo_hit    = 1'b0;
    next_state = state;

    if (owed >= 5'd5 && inv_5 != '0)      sel_coin = COIN_5;
    else if (owed >= 5'd2 && inv_2 != '0) sel_coin = COIN_2;
    else if (owed >= 5'd1 && inv_1 != '0) sel_coin = COIN_1;

    case (coin)
      COIN_5:  coin_val = 5'd5;
      COIN_2:  coin_val = 5'd2;
      COIN_1:  coin_val = 5'd1;
      default: coin_val = 5'd0;
    endcase

    if (state == DISPENSE) begin
      ack_hit = bus.hopper_ack;
      tmo_hit = !bus.hopper_ack && (tcnt == T_LAST);
    end

    case (state)
      IDLE:     if (bus.start) next_state = SELECT;
      SELECT:   next_state = (sel_coin != COIN_NONE) ? DISPENSE : FINISH;
      DISPENSE: begin
        if (ack_hit)      next_state = SELECT;
        else if (tmo_hit) next_state = FINISH;
      end
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Datapath: owed, inventory, selected coin, timeout counter, end flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owed    <= '0;
      inv_5   <= '0;
      inv_2   <= '0;
      inv_1   <= '0;
      coin    <= COIN_NONE;
      tcnt    <= '0;
      short_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.restock) begin
            inv_5 <= bus.restock_5;
            inv_2 <= bus.restock_2;
            inv_1 <= bus.restock_1;
          end
          if (bus.start) begin
            owed    <= bus.change_amt;
            short_q <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        SELECT: begin
          coin <= sel_coin;
          tcnt <= '0;
          if (sel_coin == COIN_NONE && owed != 5'd0) short_q <= 1'b1;
        end
        DISPENSE: begin
          if (ack_hit) begin
            owed <= owed - coin_val;
            case (coin)
              COIN_5:  inv_5 <= inv_5 - INV_W'(1);
              COIN_2:  inv_2 <= inv_2 - INV_W'(1);
              COIN_1:  inv_1 <= inv_1 - INV_W'(1);
              default: ;
            endcase
          end else if (tmo_hit) begin
            fault_q <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset clears them immediately
  assign bus.dispense_5 = (state == DISPENSE) && (coin == COIN_5);
  assign bus.dispense_2 = (state == DISPENSE) && (coin == COIN_2);
  assign bus.dispense_1 = (state == DISPENSE) && (coin == COIN_1);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == FINISH);
  assign bus.short_err  = (state == FINISH) && short_q;
  assign bus.fault      = (state == FINISH) && fault_q;
  assign bus.owed       = owed;
  assign bus.inv_5      = inv_5;
  assign bus.inv_2      = inv_2;
  assign bus.inv_1      = inv_1;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter INV_W, default 4: width of each coin inventory counter.
REQ-002 Parameter ACK_TIMEOUT, default 15: number of cycles to wait for hopper_ack before faulting.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to dispense change_amt; sampled only in IDLE.
REQ-006 change_amt  input  5  change owed in units of 1 (0..31); captured on an accepted start.
REQ-007 restock  input  1  loads the inventory counters; honoured only in IDLE.
REQ-008 restock_5, restock_2, restock_1  input  INV_W each  absolute coin counts loaded on restock.
REQ-009 hopper_ack  input  1  hopper confirms the requested coin was ejected.
REQ-010 dispense_5, dispense_2, dispense_1  output  1 each  coin request, at most one high, held until ack or timeout.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse at the end of each transaction.
REQ-013 short_err  output  1  one-cycle pulse, coincident with done, when change could not be completed from inventory.
REQ-014 fault  output  1  one-cycle pulse, coincident with done, on hopper_ack timeout.
REQ-015 owed  output  5  remaining change; after done, holds the undelivered amount.
REQ-016 inv_5, inv_2, inv_1  output  INV_W each  current coin counts.

Function
REQ-017 FSM states: IDLE, SELECT, DISPENSE, FINISH.
REQ-018 IDLE, start=1: owed<=change_amt; next state SELECT. A start while busy is ignored.
REQ-019 IDLE, restock=1: inventories load their restock_* values on the same edge. If start is also high, start is accepted too, and SELECT uses the reloaded counts.
REQ-020 restock outside IDLE is ignored.
REQ-021 SELECT lasts one cycle and applies a greedy choice:
  - 5 if owed>=5 and inv_5>0; else
  - 2 if owed>=2 and inv_2>0; else
  - 1 if owed>=1 and inv_1>0.
REQ-022 SELECT with a coin chosen: next state DISPENSE; the matching dispense_* is high from the next cycle.
REQ-023 SELECT with owed=0: next state FINISH, done only.
REQ-024 SELECT with owed>0 and no eligible coin: next state FINISH, done and short_err.
REQ-025 DISPENSE: on a cycle with hopper_ack=1:
  - owed decrements by the coin value and that inventory decrements by 1 on that edge;
  - dispense_* is low from the next cycle;
  - next state SELECT.
REQ-026 DISPENSE: a timeout counter clears on entry and increments each cycle without ack. When it reaches ACK_TIMEOUT:
  - dispense_* drops;
  - owed and inventory are unchanged;
  - next state FINISH with done and fault.
REQ-027 hopper_ack outside DISPENSE is ignored.
REQ-028 FINISH lasts one cycle: done (plus short_err/fault where applicable) is asserted, then the FSM returns to IDLE.
REQ-029 Latency: accepted start at edge N gives the first dispense_* at cycle N+2. Each coin costs 1 SELECT cycle plus the DISPENSE cycles until ack.
REQ-030 Inventory never underflows and never wraps; a counter at 0 is never selected.
REQ-031 owed never goes negative, because greedy selection guarantees coin value <= owed.

Reset
REQ-032 rst_n=0 at any time, including mid-DISPENSE, immediately forces:
  - state IDLE;
  - all dispense_*, busy, done, short_err, fault = 0;
  - owed = 0;
  - inv_5, inv_2, inv_1 = 0;
  - timeout counter = 0.
REQ-033 Release of rst_n requires no additional cycle before start is accepted.

Verification
REQ-034 restock 3/3/3, start change_amt=8, ack 1 cycle after each request -> dispense_5, dispense_2, dispense_1 in order; done; owed=0; inv=2/2/2.
REQ-035 start change_amt=0 -> no dispense_*; done at cycle N+2; busy high for 2 cycles.
REQ-036 restock 0/1/0, change_amt=4 -> one dispense_2; then done+short_err; owed=2; inv_2=0.
REQ-037 restock 15/15/15, change_amt=31 -> six dispense_5 then one dispense_1; owed=0; inv=9/15/14.
REQ-038 change_amt=5 with hopper_ack held low -> dispense_5 high for exactly 15 cycles; then done+fault; owed=5; inv_5 unchanged.
REQ-039 start pulsed mid-transaction is ignored, and restock in DISPENSE is ignored. rst_n low mid-DISPENSE -> all outputs 0 asynchronously; a new start after release completes normally.
